// File: rtl/alu_iter_md.sv
// alu_iter_md: handshaked integer ALU with registered results and
// iterative RV32M multiply (shift-add) and divide (restoring).
module alu_iter_md #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zero,
   output logic             sign,
   output logic             cout,
   output logic             overflow,
   output logic             busy
);

   localparam int SHW = $clog2(WIDTH);
   localparam int M   = WIDTH - 1;
   localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [SHW-1:0]   LAST = SHW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   state_t             r_state;
   logic               r_in_ready;
   logic               r_out_valid;
   logic               r_busy;
   logic [WIDTH-1:0]   r_out;
   logic               r_zero;
   logic               r_sign;
   logic               r_cout;
   logic               r_ovf;

   // Iteration state: multiply keeps {hi, multiplier}, divide keeps
   // {remainder, dividend/quotient}; r_b is multiplicand or divisor.
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_b;
   logic [SHW-1:0]     r_cnt;
   logic               r_isdiv;
   logic               r_neg;
   logic               r_sel;

   logic [SHW-1:0]     w_shamt;
   logic [WIDTH:0]     w_add;
   logic [WIDTH:0]     w_sub;
   logic [WIDTH-1:0]   w_sra;
   logic               w_dz;
   logic               w_sovf;
   logic [WIDTH-1:0]   w_imm_res;
   logic               w_imm_c;
   logic               w_imm_v;
   logic               w_go_busy;

   logic               w_sg1;
   logic               w_sg2;
   logic [WIDTH-1:0]   w_mag1;
   logic [WIDTH-1:0]   w_mag2;
   logic               w_isdiv;
   logic               w_neg;
   logic               w_sel;

   logic [WIDTH:0]     w_msum;
   logic [2*WIDTH-1:0] w_mstep;
   logic [WIDTH:0]     w_dsh;
   logic [WIDTH:0]     w_ddif;
   logic               w_dok;
   logic [2*WIDTH-1:0] w_dstep;
   logic [2*WIDTH-1:0] w_step;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_dval;
   logic [WIDTH-1:0]   w_dres;
   logic [WIDTH-1:0]   w_fin;

   assign w_shamt = src2[SHW-1:0];
   assign w_add   = {1'b0, src1} + {1'b0, src2};
   assign w_sub   = {1'b0, src1} - {1'b0, src2};
   assign w_sra   = $signed(src1) >>> w_shamt;
   assign w_dz    = (src2 == '0);
   assign w_sovf  = (src1 == MIN) && (src2 == '1);

   // Single-cycle results, including divide corner cases
   always_comb begin
      w_imm_res = '0;
      w_imm_c   = 1'b0;
      w_imm_v   = 1'b0;
      w_go_busy = 1'b0;
      case (op)
         5'h00: begin
            w_imm_res = w_add[M:0];
            w_imm_c   = w_add[WIDTH];
            w_imm_v   = (src1[M] == src2[M]) && (w_add[M] != src1[M]);
         end
         5'h01: begin
            w_imm_res = w_sub[M:0];
            w_imm_c   = w_sub[WIDTH];
            w_imm_v   = (src1[M] != src2[M]) && (w_sub[M] != src1[M]);
         end
         5'h02: w_imm_res = src1 & src2;
         5'h03: w_imm_res = src1 | src2;
         5'h04: w_imm_res = src1 ^ src2;
         5'h05: w_imm_res = src1 << w_shamt;
         5'h06: w_imm_res = src1 >> w_shamt;
         5'h07: w_imm_res = w_sra;
         5'h08: w_imm_res = {{(WIDTH-1){1'b0}},
                             $signed(src1) < $signed(src2)};
         5'h09: w_imm_res = {{(WIDTH-1){1'b0}}, src1 < src2};
         5'h10, 5'h11, 5'h12, 5'h13: w_go_busy = 1'b1;
         5'h14, 5'h16: begin
            if (w_dz)
               w_imm_res = op[1] ? src1 : '1;
            else if (w_sovf)
               w_imm_res = op[1] ? '0 : MIN;
            else
               w_go_busy = 1'b1;
         end
         5'h15, 5'h17: begin
            if (w_dz)
               w_imm_res = op[1] ? src1 : '1;
            else
               w_go_busy = 1'b1;
         end
         default: w_imm_res = '0;
      endcase
   end

   // Operand magnitudes and result-sign selection for M ops
   always_comb begin
      w_sg1   = 1'b0;
      w_sg2   = 1'b0;
      case (op)
         5'h11, 5'h14, 5'h16: begin
            w_sg1 = src1[M];
            w_sg2 = src2[M];
         end
         5'h12: w_sg1 = src1[M];
         default: ;
      endcase
      w_mag1  = w_sg1 ? -src1 : src1;
      w_mag2  = w_sg2 ? -src2 : src2;
      w_isdiv = op[2];
      w_neg   = (w_isdiv && op[1]) ? w_sg1 : (w_sg1 ^ w_sg2);
      w_sel   = w_isdiv ? op[1] : (op[1:0] != 2'b00);
   end

   // One multiply or divide bit per cycle, plus final sign fix-up
   always_comb begin
      w_msum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
              + (r_acc[0] ? {1'b0, r_b} : '0);
      w_mstep = {w_msum, r_acc[M:1]};
      w_dsh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[M]};
      w_ddif  = w_dsh - {1'b0, r_b};
      w_dok   = ~w_ddif[WIDTH];
      w_dstep = {(w_dok ? w_ddif[M:0] : w_dsh[M:0]),
                 r_acc[M-1:0], w_dok};
      w_step  = r_isdiv ? w_dstep : w_mstep;
      w_prod  = r_neg ? -w_step : w_step;
      w_dval  = r_sel ? w_step[2*WIDTH-1:WIDTH] : w_step[M:0];
      w_dres  = r_neg ? -w_dval : w_dval;
      if (r_isdiv)
         w_fin = w_dres;
      else
         w_fin = r_sel ? w_prod[2*WIDTH-1:WIDTH] : w_prod[M:0];
   end

   // Control FSM with registered handshake, result and flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_out       <= '0;
         r_zero      <= 1'b1;
         r_sign      <= 1'b0;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
         r_acc       <= '0;
         r_b         <= '0;
         r_cnt       <= '0;
         r_isdiv     <= 1'b0;
         r_neg       <= 1'b0;
         r_sel       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_in_ready <= 1'b0;
                  if (w_go_busy) begin
                     r_state <= S_BUSY;
                     r_busy  <= 1'b1;
                     r_cnt   <= '0;
                     r_isdiv <= w_isdiv;
                     r_neg   <= w_neg;
                     r_sel   <= w_sel;
                     r_acc   <= {{WIDTH{1'b0}},
                                 (w_isdiv ? w_mag1 : w_mag2)};
                     r_b     <= w_isdiv ? w_mag2 : w_mag1;
                  end else begin
                     r_state     <= S_DONE;
                     r_out_valid <= 1'b1;
                     r_out       <= w_imm_res;
                     r_zero      <= (w_imm_res == '0);
                     r_sign      <= w_imm_res[M];
                     r_cout      <= w_imm_c;
                     r_ovf       <= w_imm_v;
                  end
               end
            end
            S_BUSY: begin
               r_acc <= w_step;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == LAST) begin
                  r_state     <= S_DONE;
                  r_busy      <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_out       <= w_fin;
                  r_zero      <= (w_fin == '0);
                  r_sign      <= w_fin[M];
                  r_cout      <= 1'b0;
                  r_ovf       <= 1'b0;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign out       = r_out;
   assign zero      = r_zero;
   assign sign      = r_sign;
   assign cout      = r_cout;
   assign overflow  = r_ovf;

endmodule

// File: tb/tb_alu_iter_md.sv
// tb_alu_iter_md: directed plus random checks of alu_iter_md against
// an arithmetic reference model.
module tb_alu_iter_md;

   localparam int W = 32;
   localparam logic [W-1:0] MINV = 32'h8000_0000;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [4:0]   op;
   logic [W-1:0] src1;
   logic [W-1:0] src2;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out;
   logic         zero;
   logic         sign;
   logic         cout;
   logic         overflow;
   logic         busy;

   int n_chk = 0;
   int n_err = 0;

   alu_iter_md #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .src1      (src1),
      .src2      (src2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .zero      (zero),
      .sign      (sign),
      .cout      (cout),
      .overflow  (overflow),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model from the RV32M rules using plain arithmetic
   task automatic model(input logic [4:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, output logic [W-1:0] r,
                        output logic c, output logic v, output int lat);
      longint sa, sb, ua, ub, p;
      int ia, ib;
      logic [W:0] s33;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'h0, a});
      ub = longint'({32'h0, b});
      ia = $signed(a);
      ib = $signed(b);
      r = '0; c = 1'b0; v = 1'b0; lat = 1;
      case (o)
         5'h00: begin
            s33 = {1'b0, a} + {1'b0, b};
            r = s33[W-1:0]; c = s33[W];
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         5'h01: begin
            r = a - b; c = (a < b);
            v = (a[31] != b[31]) && (r[31] != a[31]);
         end
         5'h02: r = a & b;
         5'h03: r = a | b;
         5'h04: r = a ^ b;
         5'h05: r = a << b[4:0];
         5'h06: r = a >> b[4:0];
         5'h07: r = $signed(a) >>> b[4:0];
         5'h08: r = {31'h0, ia < ib};
         5'h09: r = {31'h0, a < b};
         5'h10: begin p = sa * sb; r = p[31:0]; lat = 33; end
         5'h11: begin p = sa * sb; r = p[63:32]; lat = 33; end
         5'h12: begin p = sa * ub; r = p[63:32]; lat = 33; end
         5'h13: begin p = ua * ub; r = p[63:32]; lat = 33; end
         5'h14: begin
            if (b == 0) r = '1;
            else if (a == MINV && b == '1) r = MINV;
            else begin r = ia / ib; lat = 33; end
         end
         5'h15: begin
            if (b == 0) r = '1;
            else begin r = a / b; lat = 33; end
         end
         5'h16: begin
            if (b == 0) r = a;
            else if (a == MINV && b == '1) r = '0;
            else begin r = ia % ib; lat = 33; end
         end
         5'h17: begin
            if (b == 0) r = a;
            else begin r = a % b; lat = 33; end
         end
         default: r = '0;
      endcase
   endtask

   task automatic do_op(input logic [4:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int hold);
      logic [W-1:0] er;
      logic ec, ev;
      int el, n;
      bit got;
      model(o, a, b, er, ec, ev, el);
      @(negedge clk);
      chk("in_ready_idle", in_ready, 1);
      in_valid = 1'b1; op = o; src1 = a; src2 = b;
      n = 0; got = 0;
      while (!got && n < 100) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         in_valid = 1'b0;
         op = 5'($urandom); src1 = $urandom; src2 = $urandom;
         if (n == 2) begin
            chk("busy_mid", busy, 1);
            chk("in_ready_busy", in_ready, 0);
         end
         if (out_valid) got = 1;
      end
      chk($sformatf("latency op%0h", o), n, el);
      chk($sformatf("out op%0h a=%h b=%h", o, a, b), out, er);
      chk("zero", zero, er == 0);
      chk("sign", sign, er[31]);
      chk("cout", cout, ec);
      chk("overflow", overflow, ev);
      for (int k = 0; k < hold; k++) begin
         in_valid = 1'b1; op = 5'h00; src1 = 1; src2 = 1;
         @(posedge clk);
         @(negedge clk);
         chk("hold_out", out, er);
         chk("hold_valid", out_valid, 1);
         chk("hold_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk("consumed_valid", out_valid, 0);
      chk("consumed_in_ready", in_ready, 1);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return 32'h1;
         2: return '1;
         3: return MINV;
         4: return W'($urandom_range(0, 20));
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      op = '0; src1 = '0; src2 = '0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out", out, 0);
      chk("rst_zero", zero, 1);
      chk("rst_sign", sign, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", overflow, 0);
      rst_n = 1'b1;

      do_op(5'h00, 32'h7FFF_FFFF, 32'h1, 0);
      do_op(5'h01, 32'h0, 32'h1, 0);
      do_op(5'h01, MINV, 32'h1, 0);
      do_op(5'h07, MINV, 32'd31, 0);
      do_op(5'h09, 32'h1, 32'hFFFF_FFFF, 0);
      do_op(5'h08, 32'hFFFF_FFFF, 32'h1, 0);
      do_op(5'h0A, 32'h1234, 32'h5678, 0);
      do_op(5'h11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      do_op(5'h13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      do_op(5'h10, 32'd7, 32'hFFFF_FFFD, 0);
      do_op(5'h12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      do_op(5'h14, 32'hFFFF_FFF9, 32'd2, 0);
      do_op(5'h16, 32'hFFFF_FFF9, 32'd2, 0);
      do_op(5'h15, 32'd5, 32'd0, 0);
      do_op(5'h17, 32'd5, 32'd0, 0);
      do_op(5'h16, MINV, 32'hFFFF_FFFF, 0);
      do_op(5'h14, MINV, 32'hFFFF_FFFF, 0);
      do_op(5'h18, 32'd9, 32'd9, 0);
      do_op(5'h15, 32'd100, 32'd7, 10);

      for (int i = 0; i < 60; i++)
         do_op(5'($urandom_range(0, 31)), pick(), pick(), 0);

      @(negedge clk);
      in_valid = 1'b1; op = 5'h10; src1 = 32'h1234_5678; src2 = 32'h9;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (11) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_in_ready", in_ready, 1);
      chk("arst_out_valid", out_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_out", out, 0);
      chk("arst_zero", zero, 1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("arst_no_result", out_valid, 0);
      do_op(5'h00, 32'd2, 32'd3, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
